adex_neuron_scheduler: RTL
==========================

ADEX_NEURON_SCHEDULER -- requirements
Module: adex_neuron_scheduler

Interface
REQ-001 Parameter N_NEURONS, default 4; number of virtual neurons time-multiplexed onto one AdEx update datapath (power of 2, 2..16).
REQ-002 Parameter STATE_W, default 16; width of membrane (v) and adaptation (w) state words, two's complement.
REQ-003 Parameter TICK_DIV, default 256; clk cycles per simulation timestep.
REQ-004 Parameter V_RST, default 16'hB000; v value loaded at reset.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 ena  input  1  run enable; 0 freezes prescaler and launches no new sweep.
REQ-008 cfg_we  input  1  write strobe for per-neuron input current.
REQ-009 cfg_addr  input  log2(N_NEURONS)  neuron index for cfg_we.
REQ-010 cfg_data  input  8  unsigned input current I for that neuron.
REQ-011 upd_req  output  1  request to datapath; operands valid while high.
REQ-012 upd_ack  input  1  datapath result valid; one-cycle pulse.
REQ-013 upd_idx  output  log2(N_NEURONS)  neuron being updated.
REQ-014 upd_v_o / upd_w_o  output  STATE_W each  current state operands.
REQ-015 upd_i_o  output  8  input current operand.
REQ-016 upd_v_i / upd_w_i  input  STATE_W each  next-state results.
REQ-017 upd_spike_i  input  1  spike flag accompanying upd_ack.
REQ-018 spk_valid  output  1  spike FIFO non-empty.
REQ-019 spk_idx  output  log2(N_NEURONS)  index of oldest spike.
REQ-020 spk_ready  input  1  pops FIFO when spk_valid high.
REQ-021 busy  output  1  sweep in progress.
REQ-022 overrun  output  1  sticky: tick arrived while busy.

Function
REQ-023 Prescaler counts 0..TICK_DIV-1 when ena=1; tick asserted for one cycle on wrap to 0.
REQ-024 FSM states IDLE, ISSUE, WAIT, COMMIT; IDLE->ISSUE on tick with idx=0.
REQ-025 ISSUE: drive upd_req=1 with operands of neuron idx; move to WAIT same edge.
REQ-026 WAIT: hold upd_req=1 and operands stable until upd_ack; then COMMIT.
REQ-027 upd_ack sampled only in WAIT; acks in other states ignored.
REQ-028 COMMIT: write upd_v_i/upd_w_i into state RAM at idx; if upd_spike_i, push idx into spike FIFO.
REQ-029 COMMIT->ISSUE with idx+1 unless idx=N_NEURONS-1, then IDLE; upd_req low in COMMIT.
REQ-030 Minimum sweep latency 3*N_NEURONS cycles (ack on first WAIT cycle); busy=1 from ISSUE through last COMMIT.
REQ-031 Tick while busy: dropped, overrun set; cleared only by reset.
REQ-032 Spike FIFO depth 4; full and spike pending: spike dropped, overrun set; simultaneous push and pop when full: pop then push, no drop.
REQ-033 Pop and push both on empty: spk_valid stays 0 that cycle, entry visible next cycle.
REQ-034 cfg_we applies next cycle; write to index currently in WAIT does not alter upd_i_o until next sweep (operand latched at ISSUE).
REQ-035 ena deasserted mid-sweep: sweep completes; prescaler frozen.

Reset
REQ-036 rst_n low: FSM IDLE, idx 0, prescaler 0, all v=V_RST, w=0, I=0, FIFO empty, upd_req 0, busy 0, overrun 0, spk_valid 0.
REQ-037 Reset mid-WAIT abandons the update; no state write occurs.

Structure
REQ-038 Shared package adex_pkg holds STATE_W, state enum type, and V_RST default.
REQ-039 One sub-module: adex_spike_fifo (depth 4, idx payload, valid/ready pop, full/empty).
REQ-040 State storage as register arrays; no SRAM macro.

Verification
REQ-041 Reset, TICK_DIV=8, ack 1 cycle after req -> first upd_req at cycle 8, idx 0,1,2,3, busy low after 12 cycles.
REQ-042 cfg_we addr=2 data=8'h40 -> upd_i_o=8'h40 when upd_idx=2, others 0.
REQ-043 upd_spike_i=1 for idx 1 and 3, spk_ready=0 -> spk_valid=1, spk_idx=1 then 3 after pops.
REQ-044 Ack delayed 10 cycles per neuron, TICK_DIV=8 -> overrun=1, operands stable during WAIT.
REQ-045 Five spikes, spk_ready=0 -> four stored, overrun=1.
REQ-046 rst_n low during WAIT of idx 2 -> v[2]=V_RST, upd_req=0 immediately.

Source files
------------

// File: rtl/adex_pkg.sv
// Shared types and defaults for the AdEx neuron scheduler and its spike FIFO.
package adex_pkg;

  localparam int unsigned STATE_W_DEF    = 16;
  localparam logic [15:0] V_RST_DEF      = 16'hB000;
  localparam int unsigned SPK_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_COMMIT
  } sched_state_t;

endpackage

// File: rtl/adex_spike_fifo.sv
// Four-entry FIFO of spiking neuron indices; a pop and a push in the same
// cycle are both honoured even when full.
module adex_spike_fifo
  import adex_pkg::*;
#(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_idx,
  input  logic         pop_ready,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] slots [SPK_FIFO_DEPTH];
  logic [1:0]   rd_ptr;
  logic [1:0]   wr_ptr;
  logic [2:0]   count;
  logic         do_pop;
  logic         do_push;

  assign empty   = (count == 3'd0);
  assign full    = (count == 3'(SPK_FIFO_DEPTH));
  assign do_pop  = pop_ready && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = slots[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int n = 0; n < int'(SPK_FIFO_DEPTH); n++) slots[n] <= '0;
    end else begin
      if (do_push) begin
        slots[wr_ptr] <= push_idx;
        wr_ptr        <= wr_ptr + 2'd1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 2'd1;
      count <= count + {2'b00, do_push} - {2'b00, do_pop};
    end
  end

endmodule

// File: rtl/adex_neuron_scheduler.sv
// AdEx neuron scheduler: one sweep over all virtual neurons per prescaler
// tick, handing each neuron's state to an external update datapath.
//   state  | meaning
//   IDLE   | waiting for tick
//   ISSUE  | operands of neuron idx presented, upd_req raised
//   WAIT   | holding request until upd_ack
//   COMMIT | writing result back, queueing spike
module adex_neuron_scheduler
  import adex_pkg::*;
#(
  parameter int unsigned        N_NEURONS = 4,
  parameter int unsigned        STATE_W   = STATE_W_DEF,
  parameter int unsigned        TICK_DIV  = 256,
  parameter logic [STATE_W-1:0] V_RST     = STATE_W'(V_RST_DEF),
  localparam int unsigned       IW        = $clog2(N_NEURONS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               cfg_we,
  input  logic [IW-1:0]      cfg_addr,
  input  logic [7:0]         cfg_data,
  output logic               upd_req,
  input  logic               upd_ack,
  output logic [IW-1:0]      upd_idx,
  output logic [STATE_W-1:0] upd_v_o,
  output logic [STATE_W-1:0] upd_w_o,
  output logic [7:0]         upd_i_o,
  input  logic [STATE_W-1:0] upd_v_i,
  input  logic [STATE_W-1:0] upd_w_i,
  input  logic               upd_spike_i,
  output logic               spk_valid,
  output logic [IW-1:0]      spk_idx,
  input  logic               spk_ready,
  output logic               busy,
  output logic               overrun
);

  localparam int unsigned   PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(N_NEURONS - 1);

  sched_state_t       state;
  logic [IW-1:0]      idx;
  logic [IW-1:0]      idx_nxt;
  logic [PW-1:0]      pre_cnt;
  logic               tick;
  logic [STATE_W-1:0] v_mem [N_NEURONS];
  logic [STATE_W-1:0] w_mem [N_NEURONS];
  logic [7:0]         i_mem [N_NEURONS];
  logic [STATE_W-1:0] res_v;
  logic [STATE_W-1:0] res_w;
  logic               res_spk;
  logic               spk_push;
  logic               spk_pop;
  logic               spk_drop;
  logic               fifo_full;
  logic               fifo_empty;

  assign tick    = ena && (pre_cnt == PW'(TICK_DIV - 1));
  assign idx_nxt = idx + IW'(1);
  assign upd_idx = idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pre_cnt <= '0;
    else if (ena) pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < int'(N_NEURONS); n++) i_mem[n] <= '0;
    end else if (cfg_we) begin
      i_mem[cfg_addr] <= cfg_data;
    end
  end

  // Operands are latched on entry to ISSUE so that later cfg writes or
  // commits cannot disturb a request that is already outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      idx     <= '0;
      upd_req <= 1'b0;
      busy    <= 1'b0;
      upd_v_o <= '0;
      upd_w_o <= '0;
      upd_i_o <= '0;
      res_v   <= '0;
      res_w   <= '0;
      res_spk <= 1'b0;
      for (int n = 0; n < int'(N_NEURONS); n++) begin
        v_mem[n] <= V_RST;
        w_mem[n] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (tick) begin
            state   <= S_ISSUE;
            idx     <= '0;
            upd_req <= 1'b1;
            busy    <= 1'b1;
            upd_v_o <= v_mem[0];
            upd_w_o <= w_mem[0];
            upd_i_o <= i_mem[0];
          end
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT: begin
          if (upd_ack) begin
            res_v   <= upd_v_i;
            res_w   <= upd_w_i;
            res_spk <= upd_spike_i;
            upd_req <= 1'b0;
            state   <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          v_mem[idx] <= res_v;
          w_mem[idx] <= res_w;
          if (idx == IDX_LAST) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            state   <= S_ISSUE;
            idx     <= idx_nxt;
            upd_req <= 1'b1;
            upd_v_o <= v_mem[idx_nxt];
            upd_w_o <= w_mem[idx_nxt];
            upd_i_o <= i_mem[idx_nxt];
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign spk_push  = (state == S_COMMIT) && res_spk;
  assign spk_pop   = spk_ready && !fifo_empty;
  assign spk_drop  = spk_push && fifo_full && !spk_pop;
  assign spk_valid = !fifo_empty;

  adex_spike_fifo #(
    .W(IW)
  ) u_spike_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (spk_push),
    .push_idx (idx),
    .pop_ready(spk_ready),
    .head     (spk_idx),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overrun <= 1'b0;
    else if ((tick && state != S_IDLE) || spk_drop) overrun <= 1'b1;
  end

endmodule
